// File: rtl/cla_seq_adder_ctrl.sv
// cla_seq_adder_ctrl: adds two WIDTH-bit operands through a single 4-bit CLA slice.
// It handles one nibble per cycle, starting with the LSB nibble. The carry is held in a
// register between nibbles.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid / in_ready operand handshake (A, B, Cin captured on accept)
//   out_valid/out_ready result handshake (S, Cout held until consumed)
//   busy                high while a sum is being formed or waiting to be consumed
//   V                   signed overflow, present only with CLA_SEQ_OVERFLOW_EN defined
//
// Optional feature macro: CLA_SEQ_OVERFLOW_EN (adds output V and its overflow logic).
//
// Also contains cla_4_bit, the 4-bit carry-lookahead slice reused for every nibble.

module cla_4_bit (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] s,
   output logic       cout
);
   logic [3:0] g;
   logic [3:0] p;
   logic [4:0] c;

   assign g = a & b;
   assign p = a ^ b;

   // Flattened lookahead equations. No ripple chain through the slice.
   assign c[0] = cin;
   assign c[1] = g[0] | (p[0] & cin);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
   assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & cin);

   assign s    = p ^ c[3:0];
   assign cout = c[4];
endmodule

module cla_seq_adder_ctrl #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] S,
   output logic             Cout,
   output logic             busy
`ifdef CLA_SEQ_OVERFLOW_EN
   ,
   output logic             V
`endif
);
   localparam int unsigned NIB = WIDTH / 4;
   localparam int unsigned CW  = (NIB > 1) ? $clog2(NIB) : 1;
   localparam logic [CW-1:0] LAST = CW'(NIB - 1);

   if ((WIDTH % 4 != 0) || (WIDTH < 4)) begin : g_bad_width
      $error("cla_seq_adder_ctrl: WIDTH must be a multiple of 4 and at least 4");
   end

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

   state_t           state_q;
   logic [CW-1:0]    cnt_q;
   logic             carry_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] s_q;
   logic             cout_q;
   logic             out_valid_q;
   logic             in_ready_q;
   logic             busy_q;

   logic [3:0]       nib_a;
   logic [3:0]       nib_b;
   logic [3:0]       nib_s;
   logic             nib_cout;

   always_comb begin
      nib_a = a_q[4*cnt_q +: 4];
      nib_b = b_q[4*cnt_q +: 4];
   end

   cla_4_bit u_slice (
      .a    (nib_a),
      .b    (nib_b),
      .cin  (carry_q),
      .s    (nib_s),
      .cout (nib_cout)
   );

`ifdef CLA_SEQ_OVERFLOW_EN
   logic v_q;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         carry_q     <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         s_q         <= '0;
         cout_q      <= 1'b0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
         busy_q      <= 1'b0;
`ifdef CLA_SEQ_OVERFLOW_EN
         v_q         <= 1'b0;
`endif
      end else begin
         unique case (state_q)
            StIdle: begin
               if (in_valid && in_ready_q) begin
                  a_q        <= A;
                  b_q        <= B;
                  carry_q    <= Cin;
                  cnt_q      <= '0;
                  s_q        <= '0;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
                  state_q    <= StRun;
               end
            end
            StRun: begin
               s_q[4*cnt_q +: 4] <= nib_s;
               carry_q           <= nib_cout;
               if (cnt_q == LAST) begin
                  cout_q      <= nib_cout;
                  out_valid_q <= 1'b1;
                  cnt_q       <= '0;
                  state_q     <= StDone;
`ifdef CLA_SEQ_OVERFLOW_EN
                  // nib_s[3] is the final MSB of the sum.
                  v_q <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (nib_s[3] != a_q[WIDTH-1]);
`endif
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            StDone: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  busy_q      <= 1'b0;
                  state_q     <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign S         = s_q;
   assign Cout      = cout_q;
   assign busy      = busy_q;
`ifdef CLA_SEQ_OVERFLOW_EN
   assign V         = v_q;
`endif
endmodule

// File: tb/tb_cla_seq_adder_ctrl.sv
// Directed testbench for cla_seq_adder_ctrl at WIDTH=16.
// Exercises reset, arithmetic corner cases, latency, backpressure, back-to-back operation and
// asynchronous reset in the middle of an operation.
// Define CLA_SEQ_OVERFLOW_EN to also exercise the V output.

module tb_cla_seq_adder_ctrl;
   localparam int unsigned WIDTH = 16;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] A = '0;
   logic [WIDTH-1:0] B = '0;
   logic             Cin = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] S;
   logic             Cout;
   logic             busy;
`ifdef CLA_SEQ_OVERFLOW_EN
   logic             V;
`endif

   int passed = 0;
   int total  = 0;

   cla_seq_adder_ctrl #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .Cin       (Cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .S         (S),
      .Cout      (Cout),
      .busy      (busy)
`ifdef CLA_SEQ_OVERFLOW_EN
      ,
      .V         (V)
`endif
   );

   always #5 clk = ~clk;

   // Presents operands for one accept edge, then counts edges until out_valid appears.
   // lat is left at 0 on timeout. Outputs are sampled 1 time unit after each rising edge.
   task automatic start_and_wait(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic cin, output int lat);
      lat = 0;
      @(negedge clk);
      A = a; B = b; Cin = cin; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk);
         #1;
         if (out_valid === 1'b1) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic consume();
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      total++; if (S !== 16'h0000) $display("FAIL reset_S got %h want 0000", S); else passed++;
      total++; if (Cout !== 1'b0) $display("FAIL reset_Cout got %b want 0", Cout); else passed++;
      total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid);
      else passed++;
      total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready);
      else passed++;
   endtask

   task automatic test_basic_add();
      int lat;
      start_and_wait(16'h1234, 16'h0F0F, 1'b0, lat);
      total++; if (lat != 4) $display("FAIL basic_latency got %0d want 4", lat); else passed++;
      total++; if (S !== 16'h2143) $display("FAIL basic_S got %h want 2143", S); else passed++;
      total++; if (Cout !== 1'b0) $display("FAIL basic_Cout got %b want 0", Cout); else passed++;
      total++; if (busy !== 1'b1) $display("FAIL basic_busy got %b want 1", busy); else passed++;
`ifdef CLA_SEQ_OVERFLOW_EN
      total++; if (V !== 1'b0) $display("FAIL basic_V got %b want 0", V); else passed++;
`endif
      consume();
      total++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
         $display("FAIL basic_release got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
      else passed++;
   endtask

   task automatic test_carry_ripple();
      int lat;
      start_and_wait(16'hFFFF, 16'h0001, 1'b0, lat);
      total++; if (lat != 4 || S !== 16'h0000 || Cout !== 1'b1)
         $display("FAIL ripple got lat=%0d S=%h Cout=%b want 4 0000 1", lat, S, Cout);
      else passed++;
      consume();
      start_and_wait(16'h0000, 16'h0000, 1'b1, lat);
      total++; if (S !== 16'h0001 || Cout !== 1'b0)
         $display("FAIL cin_only got S=%h Cout=%b want 0001 0", S, Cout);
      else passed++;
      consume();
      start_and_wait(16'hFFFF, 16'hFFFF, 1'b1, lat);
      total++; if (S !== 16'hFFFF || Cout !== 1'b1)
         $display("FAIL all_ones got S=%h Cout=%b want ffff 1", S, Cout);
      else passed++;
      consume();
   endtask

   task automatic test_back_to_back();
      int lat;
      // Carry must be reloaded from Cin, not inherited from the previous all-ones add.
      start_and_wait(16'h0000, 16'h0000, 1'b0, lat);
      total++; if (S !== 16'h0000 || Cout !== 1'b0)
         $display("FAIL b2b_zero got S=%h Cout=%b want 0000 0", S, Cout);
      else passed++;
      consume();
      start_and_wait(16'hA5A5, 16'h5A5B, 1'b0, lat);
      total++; if (S !== 16'h0000 || Cout !== 1'b1)
         $display("FAIL b2b_alt got S=%h Cout=%b want 0000 1", S, Cout);
      else passed++;
      consume();
   endtask

   task automatic test_backpressure();
      int lat;
      start_and_wait(16'h1234, 16'h0F0F, 1'b0, lat);
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         A = 16'hAAAA ^ 16'(i); B = 16'h5555; Cin = 1'b1;
         @(posedge clk);
         #1;
         total++;
         if (S !== 16'h2143 || Cout !== 1'b0 || out_valid !== 1'b1 || in_ready !== 1'b0)
            $display("FAIL hold_%0d got S=%h Cout=%b ov=%b ir=%b want 2143 0 1 0",
                     i, S, Cout, out_valid, in_ready);
         else passed++;
      end
      in_valid = 1'b0;
      consume();
      total++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0)
         $display("FAIL hold_release got ir=%b ov=%b busy=%b want 1 0 0",
                  in_ready, out_valid, busy);
      else passed++;
   endtask

   task automatic test_reset_mid_run();
      int lat;
      @(negedge clk);
      A = 16'hFFFF; B = 16'hFFFF; Cin = 1'b1; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      total++; if (S !== 16'h0000 || Cout !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0)
         $display("FAIL midreset got S=%h Cout=%b ov=%b busy=%b want 0000 0 0 0",
                  S, Cout, out_valid, busy);
      else passed++;
      @(negedge clk);
      rst_n = 1'b1;
      start_and_wait(16'h00FF, 16'h0001, 1'b0, lat);
      total++; if (lat != 4 || S !== 16'h0100 || Cout !== 1'b0)
         $display("FAIL after_reset got lat=%0d S=%h Cout=%b want 4 0100 0", lat, S, Cout);
      else passed++;
      consume();
   endtask

`ifdef CLA_SEQ_OVERFLOW_EN
   task automatic test_overflow();
      int lat;
      start_and_wait(16'h7FFF, 16'h0001, 1'b0, lat);
      total++; if (V !== 1'b1 || S !== 16'h8000)
         $display("FAIL ovf_pos got V=%b S=%h want 1 8000", V, S);
      else passed++;
      consume();
      start_and_wait(16'h8000, 16'h8000, 1'b0, lat);
      total++; if (V !== 1'b1 || S !== 16'h0000 || Cout !== 1'b1)
         $display("FAIL ovf_neg got V=%b S=%h Cout=%b want 1 0000 1", V, S, Cout);
      else passed++;
      consume();
      start_and_wait(16'h1234, 16'h0F0F, 1'b0, lat);
      total++; if (V !== 1'b0) $display("FAIL ovf_none got V=%b want 0", V); else passed++;
      consume();
   endtask
`endif

   initial begin
      test_reset();
      test_basic_add();
      test_carry_ripple();
      test_back_to_back();
      test_backpressure();
      test_reset_mid_run();
`ifdef CLA_SEQ_OVERFLOW_EN
      test_overflow();
`endif
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
